// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller. Issues single outstanding
//               instruction-memory requests, buffers one fetched word for
//               the decode stage, and handles redirects (including a flush
//               of an in-flight request whose data must be dropped).
// Option      : FETCH_ALIGN_CHECK_EN -- when defined, a redirect to a
//               non-word-aligned target raises trap and parks the fetcher
//               in IDLE; when undefined the low target bits are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] fetch_count,
  output logic        trap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;        // next address to fetch once the current work drains
  logic [31:0] req_addr;  // address presented while a request is outstanding
  logic [31:0] tgt;       // effective redirect target
  logic        redir_ok;  // redirect that is accepted and moves pc
  logic        redir_bad; // redirect rejected for misalignment
  logic        transfer;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt       = redirect_pc;
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);
  assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);

  // Sticky misalignment flag, cleared only by an aligned redirect or reset
  always_ff @(posedge clock) begin
    if (reset) begin
      trap <= 1'b0;
    end else if (redir_bad) begin
      trap <= 1'b1;
    end else if (redir_ok) begin
      trap <= 1'b0;
    end
  end
`else
  logic unused_low_bits;
  // Word fetches only: the byte-offset bits of a target carry no meaning
  assign unused_low_bits = ^redirect_pc[1:0];
  assign tgt       = {redirect_pc[31:2], 2'b00};
  assign redir_bad = 1'b0;
  assign redir_ok  = redirect;
  assign trap      = 1'b0;
`endif

  assign imem_req  = (state == S_FETCH) || (state == S_FLUSH);
  assign imem_addr = req_addr;
  assign id_valid  = (state == S_HOLD);
  assign transfer  = (state == S_HOLD) && id_ready;

  // Fetch sequencing: redirect first, then the per-state request/hold flow
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      // A delivered word counts even if a redirect lands in the same cycle
      if (transfer) begin
        fetch_count <= fetch_count + 32'd1;
      end

      if (redir_bad) begin
        // Abandon everything and wait for software to supply a sane target
        state <= S_IDLE;
      end else if (redir_ok) begin
        pc <= tgt;
        if (imem_req && !imem_ack) begin
          // Memory still owes us a word for the old address; swallow it
          state <= S_FLUSH;
        end else if (stall) begin
          state <= S_IDLE;
        end else begin
          state    <= S_FETCH;
          req_addr <= tgt;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (!stall && !trap) begin
              state    <= S_FETCH;
              req_addr <= pc;
            end
          end
          S_FETCH: begin
            if (imem_ack) begin
              id_instr <= imem_rdata;
              id_pc    <= req_addr;
              pc       <= req_addr + 32'd4;
              state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (id_ready) begin
              if (stall) begin
                state <= S_IDLE;
              end else begin
                state    <= S_FETCH;
                req_addr <= pc;
              end
            end
          end
          S_FLUSH: begin
            if (imem_ack) begin
              if (stall) begin
                state <= S_IDLE;
              end else begin
                state    <= S_FETCH;
                req_addr <= pc;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl: directed scenarios plus a
//               randomized run against a transaction-level address model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] fetch_count;
  logic        trap;

  int total = 0;
  int bad = 0;

  // Memory responder: 0 = driven by the test, 1 = fixed delay, 2 = random
  int mem_mode = 0;
  int ack_delay = 1;
  int wait_cnt = 0;

  always #5 clock = ~clock;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .fetch_count(fetch_count), .trap(trap)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model answers just after each rising edge
  always @(posedge clock) begin
    #1;
    if (mem_mode != 0) begin
      imem_rdata = mem_word(imem_addr);
      if (imem_req !== 1'b1) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_mode == 1) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    mem_mode = 0; imem_ack = 1'b0; wait_cnt = 0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    id_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Drain to IDLE by stalling; leaves stall=1 at a falling edge
  task automatic go_idle();
    bit done;
    done = 0;
    stall = 1'b1; id_ready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clock);
      if (imem_req === 1'b0 && id_valid === 1'b0) done = 1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL idle_timeout: got busy want idle"); end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; mem_mode = 0; imem_ack = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", id_instr); end
    total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", id_pc); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rst_count: got %h want 0", fetch_count); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL rst_trap: got %b want 0", trap); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL rst_first_fetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] acked[$];
    int  n;
    bit  exp_valid, prev_xfer;
    n = 0; exp_valid = 0; prev_xfer = 0;
    do_reset();
    mem_mode = 1; ack_delay = 1; id_ready = 1'b1; stall = 1'b0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clock);
      if (exp_valid) begin
        total++;
        if (id_valid !== 1'b1) begin bad++; $display("FAIL seq_latency: got valid=%b want 1", id_valid); end
      end
      if (prev_xfer) begin
        total++;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_bubble: got req=%b want 1", imem_req); end
      end
      exp_valid = (imem_req === 1'b1) && imem_ack;
      if (exp_valid) acked.push_back(imem_addr);
      prev_xfer = (id_valid === 1'b1) && id_ready;
      if (prev_xfer) begin
        total++;
        if (id_pc !== RESET_PC + 32'(4 * n) || id_instr !== mem_word(RESET_PC + 32'(4 * n))) begin
          bad++; $display("FAIL seq_deliver: got pc=%h instr=%h want pc=%h", id_pc, id_instr, RESET_PC + 32'(4 * n));
        end
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL seq_timeout: got %0d transfers want 4", n); end
    total++;
    if (acked.size() < 4) begin
      bad++; $display("FAIL seq_reqs: got %0d requests want 4", acked.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acked[i] !== RESET_PC + 32'(4 * i)) begin
          bad++; $display("FAIL seq_addr: got %h want %h", acked[i], RESET_PC + 32'(4 * i));
        end
      end
    end
    @(negedge clock);
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_hold();
    bit seen;
    seen = 0;
    id_ready = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (id_valid === 1'b1) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL hold_timeout: got no valid want valid"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (id_valid !== 1'b1 || id_pc !== RESET_PC + 32'd16 || id_instr !== mem_word(RESET_PC + 32'd16) || imem_req !== 1'b0) begin
        bad++; $display("FAIL hold_stable: got v=%b pc=%h instr=%h req=%b want v=1 pc=%h req=0",
                        id_valid, id_pc, id_instr, imem_req, RESET_PC + 32'd16);
      end
      @(negedge clock);
    end
    id_ready = 1'b1;
    @(negedge clock);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd20) begin
      bad++; $display("FAIL hold_next: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC + 32'd20);
    end
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL hold_count: got %0d want 5", fetch_count); end
  endtask

  task automatic test_redirect_flush();
    bit found;
    found = 0;
    do_reset();
    id_ready = 1'b1; stall = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      imem_rdata = mem_word(imem_addr);
      imem_ack = (imem_req === 1'b1) && (imem_addr !== 32'h8);
      if (imem_req === 1'b1 && imem_addr === 32'h8) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL flush_reach: got no fetch at 8 want fetch at 8"); end
    redirect = 1'b1; redirect_pc = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      redirect = 1'b0;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || id_valid !== 1'b0) begin
        bad++; $display("FAIL flush_wait: got req=%b addr=%h v=%b want req=1 addr=8 v=0", imem_req, imem_addr, id_valid);
      end
      if (k == 3) begin imem_ack = 1'b1; imem_rdata = mem_word(32'h8); end
    end
    @(negedge clock);
    imem_ack = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      bad++; $display("FAIL flush_target: got req=%b addr=%h v=%b want req=1 addr=100 v=0", imem_req, imem_addr, id_valid);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h100);
    @(negedge clock);
    imem_ack = 1'b0;
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin
      bad++; $display("FAIL flush_deliver: got v=%b pc=%h instr=%h want v=1 pc=100 instr=%h",
                      id_valid, id_pc, id_instr, mem_word(32'h100));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] acked[$];
    logic [31:0] deliv[$];
    mem_mode = 1; ack_delay = 0; wait_cnt = 0;
    go_idle();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; stall = 1'b0; id_ready = 1'b1;
    for (int c = 0; c < 30 && deliv.size() < 2; c++) begin
      @(negedge clock);
      redirect = 1'b0;
      if (imem_req === 1'b1 && imem_ack) acked.push_back(imem_addr);
      if (id_valid === 1'b1 && id_ready) begin
        deliv.push_back(id_pc);
        total++;
        if (id_instr !== mem_word(id_pc)) begin bad++; $display("FAIL wrap_instr: got %h want %h", id_instr, mem_word(id_pc)); end
      end
    end
    total++;
    if (acked.size() < 2 || deliv.size() < 2) begin
      bad++; $display("FAIL wrap_timeout: got %0d acks %0d deliveries want 2 and 2", acked.size(), deliv.size());
    end else begin
      total++;
      if (acked[0] !== 32'hFFFF_FFFC || acked[1] !== 32'h0) begin
        bad++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", acked[0], acked[1]);
      end
      total++;
      if (deliv[0] !== 32'hFFFF_FFFC || deliv[1] !== 32'h0) begin
        bad++; $display("FAIL wrap_pc: got %h,%h want fffffffc,00000000", deliv[0], deliv[1]);
      end
    end
  endtask

  task automatic test_misaligned();
    mem_mode = 1; ack_delay = 0;
    go_idle();
    redirect = 1'b1; redirect_pc = 32'h102; stall = 1'b0;
    @(negedge clock);
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      total++;
      if (trap !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin
        bad++; $display("FAIL mis_trap: got trap=%b req=%b v=%b want trap=1 req=0 v=0", trap, imem_req, id_valid);
      end
      @(negedge clock);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clock);
    redirect = 1'b0;
    total++;
    if (trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL mis_clear: got trap=%b req=%b addr=%h want trap=0 req=1 addr=200", trap, imem_req, imem_addr);
    end
`else
    total++;
    if (trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++; $display("FAIL mis_round: got trap=%b req=%b addr=%h want trap=0 req=1 addr=100", trap, imem_req, imem_addr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit busy;
    busy = 0;
    mem_mode = 0; imem_ack = 1'b0; stall = 1'b0; id_ready = 1'b1;
    for (int c = 0; c < 10 && !busy; c++) begin
      @(negedge clock);
      if (imem_req === 1'b1) busy = 1;
    end
    total++; if (!busy) begin bad++; $display("FAIL rmid_reach: got no request want request"); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    total++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || fetch_count !== 32'h0) begin
      bad++; $display("FAIL rmid_state: got req=%b v=%b cnt=%0d want 0 0 0", imem_req, id_valid, fetch_count);
    end
    @(negedge clock);
    imem_ack = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || id_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_refetch: got req=%b addr=%h v=%b want req=1 addr=%h v=0", imem_req, imem_addr, id_valid, RESET_PC);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(RESET_PC);
    @(negedge clock);
    imem_ack = 1'b0;
    total++;
    if (id_valid !== 1'b1 || id_pc !== RESET_PC || id_instr !== mem_word(RESET_PC)) begin
      bad++; $display("FAIL rmid_deliver: got v=%b pc=%h instr=%h want v=1 pc=%h", id_valid, id_pc, id_instr, RESET_PC);
    end
  endtask

  // Transaction model: delivered words follow exp_pc, advancing by 4 per
  // transfer and jumping to the target on every redirect.
  task automatic test_random();
    logic [31:0] exp_pc, p_addr, r;
    int unsigned xfers;
    bit stale, e_drop, e_valid, e_req, e_addr, xfer;
    do_reset();
    mem_mode = 2;
    exp_pc = RESET_PC; xfers = 0; stale = 0;
    e_drop = 0; e_valid = 0; e_req = 0; e_addr = 0; p_addr = 32'h0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (e_drop) begin
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rnd_drop: got v=%b want 0", id_valid); end
      end
      if (e_valid) begin
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL rnd_latency: got v=%b want 1", id_valid); end
      end
      if (e_req) begin
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rnd_req: got req=%b want 1", imem_req); end
      end
      if (e_addr) begin
        total++; if (imem_addr !== p_addr) begin bad++; $display("FAIL rnd_addr_stable: got %h want %h", imem_addr, p_addr); end
      end
      total++; if (fetch_count !== 32'(xfers)) begin bad++; $display("FAIL rnd_count: got %0d want %0d", fetch_count, xfers); end
      total++; if (trap !== 1'b0) begin bad++; $display("FAIL rnd_trap: got %b want 0", trap); end
      if (id_valid === 1'b1) begin
        total++;
        if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc)) begin
          bad++; $display("FAIL rnd_deliver: got pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, exp_pc, mem_word(exp_pc));
        end
      end
      if (imem_req === 1'b1 && !stale) begin
        total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL rnd_fetch_addr: got %h want %h", imem_addr, exp_pc); end
      end

      stall    = ($urandom_range(0, 3) == 0);
      id_ready = ($urandom_range(0, 2) != 0);
      redirect = ($urandom_range(0, 11) == 0);
      r = $urandom;
      r[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFFC;
      redirect_pc = r;

      xfer = (id_valid === 1'b1) && id_ready;
      e_drop = 0; e_valid = 0; e_req = 0; e_addr = 0;
      if (xfer) begin xfers++; exp_pc = exp_pc + 32'd4; end
      if (imem_req === 1'b1 && imem_ack) begin
        e_valid = !stale && !redirect;
        stale = 0;
      end else if (imem_req === 1'b1) begin
        e_req = 1; e_addr = 1; p_addr = imem_addr;
        if (redirect) stale = 1;
      end
      if (redirect) begin
        e_drop = 1; exp_pc = r;
        if (!stall) e_req = 1;
      end
      if (xfer && !stall && !redirect) e_req = 1;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_redirect_flush();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Port clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  is a synchronous, active-high reset.
REQ-004 Port stall  input  1  SHALL block issue of new fetches while high.
REQ-005 Port redirect  input  1  is a branch/jump request; it is valid in the same cycle.
REQ-006 Port redirect_pc  input  32  is the redirect target, sampled when redirect=1.
REQ-007 Port imem_req  output  1  is the instruction-memory request.
REQ-008 Port imem_addr  output  32  is the fetch byte address; it SHALL stay stable while imem_req=1.
REQ-009 Port imem_ack  input  1  is a single-cycle memory completion; imem_rdata is valid in the same cycle.
REQ-010 Port imem_rdata  input  32  is the fetched instruction word.
REQ-011 Port id_valid  output  1  SHALL be high when id_instr/id_pc hold a deliverable instruction.
REQ-012 Port id_ready  input  1  is the decode-stage accept; transfer occurs when id_valid&id_ready.
REQ-013 Port id_instr  output  32  is the buffered instruction.
REQ-014 Port id_pc  output  32  is the address of id_instr.
REQ-015 Port fetch_count  output  32  counts delivered instructions.
REQ-016 Port trap  output  1  is the misaligned-target flag (REQ-034).

Function
REQ-017 FSM states SHALL be IDLE, FETCH, HOLD and FLUSH; reset enters IDLE.
REQ-018 IDLE: imem_req=0; go to FETCH the next cycle if stall=0, otherwise stay.
REQ-019 FETCH: imem_req=1 and imem_addr=req_addr; on imem_ack, capture imem_rdata/req_addr into id_instr/id_pc, set pc=pc+4 and go to HOLD.
REQ-020 id_valid SHALL rise the cycle after imem_ack; fetch-to-valid latency is 1 cycle after ack.
REQ-021 HOLD: id_valid=1 and outputs stable until id_ready=1; then go to FETCH if stall=0, else to IDLE.
REQ-022 A transfer in HOLD with stall=0 SHALL assert imem_req in the very next cycle; there are no bubbles beyond memory latency.
REQ-023 stall SHALL NOT abort an outstanding request and SHALL NOT clear id_valid.
REQ-024 redirect has top priority in every state: pc=redirect_pc and id_valid=0 from the next cycle.
REQ-025 redirect in FETCH without imem_ack SHALL go to FLUSH; imem_req stays high at the old address until ack, and that ack's data SHALL be discarded.
REQ-026 FLUSH: on imem_ack, go to FETCH (stall=0) or IDLE (stall=1) using the redirected pc.
REQ-027 redirect in FETCH with imem_ack in the same cycle SHALL discard the data; next state is FETCH at redirect_pc, or IDLE if stall=1.
REQ-028 redirect in FLUSH SHALL update pc and remain in FLUSH.
REQ-029 redirect in HOLD or IDLE SHALL drop any buffered instruction; next state is FETCH, or IDLE if stall=1.
REQ-030 pc SHALL wrap modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-031 fetch_count SHALL increment by 1 per id_valid&id_ready transfer and wrap from 32'hFFFF_FFFF to 0.
REQ-032 A transfer coinciding with redirect SHALL still count; the redirect still takes effect.

Reset
REQ-033 On reset: state=IDLE, pc=req_addr=RESET_PC, imem_req=0, id_valid=0, id_instr=0, id_pc=0, fetch_count=0, trap=0; reset mid-request abandons it and ignores any later ack until the next request.

Configuration
REQ-034 With FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 SHALL set trap=1 from the next cycle, force IDLE, leave pc unchanged and issue no fetch; trap holds until an aligned redirect or reset.
REQ-035 Without FETCH_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be treated as 2'b00, and trap SHALL be constant 0.

Verification
REQ-036 Reset, then release with stall=0, ack 1 cycle after req, id_ready=1 -> imem_addr 0,4,8,12; id_pc matches; fetch_count=4 after four transfers.
REQ-037 id_ready=0 for 5 cycles in HOLD -> id_valid, id_instr and id_pc stable; imem_req=0; no pc advance.
REQ-038 redirect to 0x100 while FETCH at 0x8 is waiting, ack 3 cycles later -> imem_addr stays 0x8 until ack, id_valid stays 0, then imem_addr=0x100.
REQ-039 Start at pc=0xFFFF_FFFC (via redirect) -> after delivery, next imem_addr=0x0.
REQ-040 redirect_pc=0x102 -> with macro: trap=1, FSM idle, imem_req=0; without macro: fetch at 0x100, trap=0.
REQ-041 Assert reset during FETCH, then ack arrives -> id_valid=0, fetch_count=0, and the next fetch is at RESET_PC.
